tdm_demux: RTL
==============

# tdm_demux

Four-channel time-division demultiplexer: the receive end of a TDM link whose transmit end interleaves four channels onto one data bus through a select-driven multiplexer. It locks to a frame-sync pulse, steers each time slot into its own channel register and presents all four channels atomically once per frame. It sits between the serial TDM link and the per-channel consumers.

## Interface
- `WIDTH`, 1: data width of the link and of each channel.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `din`  in  WIDTH  TDM data, one slot per cycle.
- `sync`  in  1  frame sync; high in the same cycle as the slot-0 sample.
- `ch0`..`ch3`  out  WIDTH each  channel registers, updated together once per frame.
- `frame_valid`  out  1  one-cycle pulse when `ch0`..`ch3` hold a new frame.
- `locked`  out  1  high while in LOCKED.
- `sync_err`  out  1  one-cycle pulse on any sync violation.

## Operation
- Reset (`rst_n`=0, at any time, including mid-frame): state HUNT, slot counter 0, shadow registers 0, all outputs 0.
- States:
  - HUNT: counts nothing and captures nothing until `sync`=1.
  - LOCKED: slot counter `s` (2 bits) advances every cycle.
- HUNT, `sync`=1: `din` goes to shadow `sh0`, `s`<=1, go to LOCKED.
- LOCKED, normal cycle (`sync`=1 with `s`=0, or `sync`=0 with `s`≠0): `din` goes to shadow slot `s`; `s`<=`s`+1 mod 4.
- Commit at `s`=3: `ch0..ch2`<=`sh0..sh2`, `ch3`<=`din`, `frame_valid`<=1. All four channels change on the same edge; they are never partially updated.
- Early sync (`sync`=1 and `s`≠0):
  - `sync_err` pulses.
  - The partial frame is discarded; no commit occurs.
  - `din` goes to `sh0` and `s`<=1. This realigns the counter and the block stays LOCKED.
- Missing sync (`sync`=0 and `s`=0):
  - `sync_err` pulses and the block goes to HUNT.
  - `locked`<=0 and nothing is captured.
  - The `ch` registers keep their last committed frame.
- `sync`=1 at `s`=3 is an early sync. It takes priority over commit, so no `frame_valid` is produced.
- The `ch` registers hold their value between commits.

## Timing
- All outputs are registered.
- Latency: the slot-3 sample appears on `ch3` one edge after it is presented, together with `frame_valid`=1 for exactly one cycle.
- Slot-0 data reaches `ch0` 4 edges after its sync cycle.
- Steady state: `frame_valid` pulses every 4 cycles, in the cycle after each slot-3 sample.
- `locked` rises on the edge that samples the first `sync` in HUNT.
- `sync_err` and the `locked` fall are registered on the violating edge.
- Back-to-back frames need no gap cycles.

## Structure
- Shared package: `SLOT_BITS`=2, `NUM_CH`=4, state encodings `ST_HUNT`=0 and `ST_LOCKED`=1.
- Sub-module `demux_1to4`: combinational decoder. It takes the enable and 2-bit `s` and produces four one-hot load strobes. It is built structurally from the team's `and_gate`/`not_gate` cells and is the counterpart of the transmit-side select multiplexer.
- Top level contains:
  - the state register and slot counter;
  - the shadow registers `sh0`..`sh2`;
  - the commit logic and the `ch` registers.

## Test plan
- Reset then idle: `rst_n` low mid-stream, then `sync`=0 for 10 cycles. Required: all outputs stay 0 and `locked`=0.
- Clean lock, `WIDTH`=4: `sync` at cycle 0 with `din`=1,2,3,4 repeating. Required: after the 4th edge `ch0..ch3`=1,2,3,4 with `frame_valid` pulsing every 4 cycles; `locked`=1 from the first edge.
- Early sync: `sync`=1 again at `s`=2. Required:
  - `sync_err` pulses for 1 cycle and there is no `frame_valid` for that frame.
  - The next frame is aligned to the new sync; `locked` stays 1.
- Missing sync: `sync`=0 at the expected slot 0. Required:
  - `sync_err` pulses, `locked`=0.
  - `ch` registers hold 1,2,3,4.
  - Relock occurs on the next `sync`.
- Reset mid-frame: `rst_n` pulsed low at `s`=2. Required: all outputs clear immediately (asynchronously) and the block returns to HUNT.
- Sync at slot 3: `sync`=1 with `s`=3. Required: `sync_err` pulses, no commit occurs, and `ch` is unchanged.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared constants and state encoding for the four-channel TDM receive path.
package tdm_demux_pkg;

  localparam int SLOT_BITS = 2;
  localparam int NUM_CH    = 4;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/and_gate.sv
// Two-input AND cell.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/demux_1to4.sv
// One-hot slot decoder built from gate cells; mirror of the transmit-side
// select multiplexer.
module demux_1to4
  import tdm_demux_pkg::*;
(
  input  logic                 en,
  input  logic [SLOT_BITS-1:0] sel,
  output logic [NUM_CH-1:0]    strobe
);

  logic [SLOT_BITS-1:0] sel_n;
  logic [NUM_CH-1:0]    en_hi;

  generate
    for (genvar gi = 0; gi < SLOT_BITS; gi++) begin : g_inv
      not_gate u_not (.a(sel[gi]), .y(sel_n[gi]));
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
      localparam logic [SLOT_BITS-1:0] IDX = SLOT_BITS'(gi);
      logic term_hi;
      logic term_lo;
      // Each output picks the true or inverted select bit matching its index.
      assign term_hi = IDX[1] ? sel[1] : sel_n[1];
      assign term_lo = IDX[0] ? sel[0] : sel_n[0];
      and_gate u_and_hi (.a(en),        .b(term_hi), .y(en_hi[gi]));
      and_gate u_and_lo (.a(en_hi[gi]), .b(term_lo), .y(strobe[gi]));
    end
  endgenerate

endmodule

// File: rtl/not_gate.sv
// Inverter cell.
module not_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// File: rtl/tdm_demux.sv
// Four-channel TDM demultiplexer: locks to frame sync, collects slots in
// shadow registers and commits all four channels on the same edge.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  state_t                            state_reg;
  logic [SLOT_BITS-1:0]              slot_reg;
  logic [NUM_CH-2:0][WIDTH-1:0]      sh_reg;

  logic                 slot_zero;
  logic                 early_sync;
  logic                 missing_sync;
  logic                 load_en;
  logic [SLOT_BITS-1:0] load_sel;
  logic [NUM_CH-1:0]    load_strobe;

  assign slot_zero    = (slot_reg == '0);
  assign early_sync   = (state_reg == ST_LOCKED) && sync && !slot_zero;
  assign missing_sync = (state_reg == ST_LOCKED) && !sync && slot_zero;
  assign load_en      = (state_reg == ST_HUNT) ? sync : !missing_sync;
  // Any sync forces the sample into slot 0, which both realigns an early
  // sync and steers it away from the commit strobe.
  assign load_sel     = sync ? '0 : slot_reg;

  demux_1to4 u_decode (
    .en     (load_en),
    .sel    (load_sel),
    .strobe (load_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_HUNT;
      slot_reg  <= '0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= early_sync | missing_sync;
      if (missing_sync) begin
        state_reg <= ST_HUNT;
        slot_reg  <= '0;
        locked    <= 1'b0;
      end else if (load_en) begin
        state_reg <= ST_LOCKED;
        slot_reg  <= load_sel + 1'b1;
        locked    <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_reg[gi] <= '0;
        end else if (load_strobe[gi]) begin
          sh_reg[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= load_strobe[NUM_CH-1];
      if (load_strobe[NUM_CH-1]) begin
        ch0 <= sh_reg[0];
        ch1 <= sh_reg[1];
        ch2 <= sh_reg[2];
        ch3 <= din;
      end
    end
  end

endmodule
